// File: rtl/pio_edge_irq_deb.sv
// Avalon-MM input PIO: synchronises and debounces WIDTH lines, captures
// rising/falling edges in a write-1-to-clear register and drives a masked level IRQ.
module pio_edge_irq_deb #(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       DEB_W       = 16,
  parameter logic [WIDTH-1:0]  RISE_RST    = '1,
  parameter logic [WIDTH-1:0]  FALL_RST    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_RISE = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_CAP  = 3'd3;
  localparam logic [2:0] ADDR_FALL = 3'd4;
  localparam logic [2:0] ADDR_DEB  = 3'd5;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  stable, stable_d, stable_nxt;
  logic [WIDTH-1:0][DEB_W-1:0]       cnt_q, cnt_nxt;
  logic [WIDTH-1:0]                  rise_en, fall_en, irq_mask, capture;
  logic [DEB_W-1:0]                  deb_cnt;
  logic [WIDTH-1:0]                  ev, clr, capture_nxt;
  logic [31:0]                       rd_nxt;
  logic                              wr, wr_deb;
  logic                              unused_wd;

  assign s         = sync_q[SYNC_STAGES-1];
  assign wr        = chipselect & ~write_n;
  assign wr_deb    = wr && (address == ADDR_DEB);
  assign unused_wd = ^writedata;

  // Per-bit debounce: input must disagree with stable for deb_cnt consecutive cycles
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (deb_cnt == '0) begin
        stable_nxt[i] = s[i];
      end else if (s[i] != stable[i]) begin
        if (cnt_q[i] == deb_cnt - DEB_W'(1)) stable_nxt[i] = s[i];
        else                                 cnt_nxt[i]    = cnt_q[i] + DEB_W'(1);
      end
      if (wr_deb) cnt_nxt[i] = '0;
    end
  end

  // Edge events win over a simultaneous W1C clear
  always_comb begin
    ev          = (rise_en & stable & ~stable_d) | (fall_en & ~stable & stable_d);
    clr         = (wr && (address == ADDR_CAP)) ? writedata[WIDTH-1:0] : '0;
    capture_nxt = ev | (capture & ~clr);
  end

  always_comb begin
    rd_nxt = '0;
    case (address)
      ADDR_DATA: rd_nxt = 32'(stable);
      ADDR_RISE: rd_nxt = 32'(rise_en);
      ADDR_MASK: rd_nxt = 32'(irq_mask);
      ADDR_CAP:  rd_nxt = 32'(capture);
      ADDR_FALL: rd_nxt = 32'(fall_en);
      ADDR_DEB:  rd_nxt = 32'(deb_cnt);
      default:   rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable   <= '0;
      stable_d <= '0;
      cnt_q    <= '0;
      rise_en  <= RISE_RST;
      fall_en  <= FALL_RST;
      irq_mask <= '0;
      capture  <= '0;
      deb_cnt  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_port};
      stable   <= stable_nxt;
      stable_d <= stable;
      cnt_q    <= cnt_nxt;
      capture  <= capture_nxt;
      readdata <= rd_nxt;
      irq      <= |(capture & irq_mask);
      if (wr) begin
        case (address)
          ADDR_RISE: rise_en  <= writedata[WIDTH-1:0];
          ADDR_MASK: irq_mask <= writedata[WIDTH-1:0];
          ADDR_FALL: fall_en  <= writedata[WIDTH-1:0];
          ADDR_DEB:  deb_cnt  <= writedata[DEB_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule
